// File: rtl/update_knn3_acc_pkg.sv
// Shared widths and FSM state type for the update_knn3 product accumulator.
package update_knn3_acc_pkg;
  localparam int PROD_W  = 32;
  localparam int ACC_W   = 40;
  localparam int CNT_W   = 8;
  localparam int MUL_LAT = 3;

  typedef enum logic {IDLE, RUN} acc_state_t;
endpackage

// File: rtl/update_knn3_vld_pipe.sv
// {valid,last} delay line matching the multiplier pipeline; advances only on en.
module update_knn3_vld_pipe #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic in_valid,
  input  logic in_last,
  output logic tail_valid,
  output logic tail_last
);
  logic [STAGES-1:0] vld_pipe;
  logic [STAGES-1:0] lst_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else if (en) begin
      vld_pipe[0] <= in_valid;
      lst_pipe[0] <= in_last;
      for (int i = 1; i < STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
      end
    end
  end

  assign tail_valid = vld_pipe[STAGES-1];
  assign tail_last  = lst_pipe[STAGES-1];
endmodule

// File: rtl/update_knn3_prod_acc.sv
// Sums multiplier products per group and emits one result per group on a valid/ready port.
// UPDATE_KNN3_ACC_SAT_EN: clamp the sum to all-ones on overflow instead of wrapping.
module update_knn3_prod_acc
  import update_knn3_acc_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LAT,
  parameter int PROD_WIDTH  = PROD_W,
  parameter int ACC_WIDTH   = ACC_W,
  parameter int CNT_WIDTH   = CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mul_ce,
  input  logic [PROD_WIDTH-1:0] mul_dout,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [ACC_WIDTH-1:0]  sum_data,
  output logic [CNT_WIDTH-1:0]  sum_count,
  output logic                  sum_ovf
);
  acc_state_t           state;
  logic                 tail_valid, tail_last, step;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 ovf, ovf_nxt;
  logic [ACC_WIDTH:0]   sum_ext;

  // The output register is free or draining whenever ce is high, so a publish never overwrites a held result.
  assign mul_ce   = !(sum_valid && !sum_ready);
  assign in_ready = mul_ce;
  assign step     = mul_ce && tail_valid;

  update_knn3_vld_pipe #(.STAGES(MUL_LATENCY)) u_vld_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (mul_ce),
    .in_valid  (in_valid && mul_ce),
    .in_last   (in_last),
    .tail_valid(tail_valid),
    .tail_last (tail_last)
  );

  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_WIDTH+1)'(mul_dout);
    acc_nxt = ACC_WIDTH'(mul_dout);
    cnt_nxt = CNT_WIDTH'(1);
    ovf_nxt = 1'b0;
    if (state == RUN) begin
      cnt_nxt = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
      ovf_nxt = ovf | sum_ext[ACC_WIDTH];
`ifdef UPDATE_KNN3_ACC_SAT_EN
      acc_nxt = ovf_nxt ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
      acc_nxt = sum_ext[ACC_WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_count <= '0;
      sum_ovf   <= 1'b0;
    end else begin
      if (sum_valid && sum_ready) sum_valid <= 1'b0;
      if (step) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
        if (tail_last) begin
          state     <= IDLE;
          sum_valid <= 1'b1;
          sum_data  <= acc_nxt;
          sum_count <= cnt_nxt;
          sum_ovf   <= ovf_nxt;
        end else begin
          state <= RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_update_knn3_prod_acc.sv
// Scoreboard bench: 40-bit and 32-bit accumulators fed by a ce-gated 3-stage multiplier model.
module tb_update_knn3_prod_acc;
  typedef struct packed {
    logic [39:0] data;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, sum_ready = 1'b1;
  logic        in_ready, mul_ce, sum_valid, sum_ovf;
  logic [39:0] sum_data;
  logic [7:0]  sum_count;
  logic        in_ready32, mul_ce32, sum_valid32, sum_ovf32;
  logic [31:0] sum_data32;
  logic [7:0]  sum_count32;
  logic [31:0] din = '0, m0, m1, m2;

  exp_t q40[$];
  exp_t q32[$];
  int   vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  // Multiplier stand-in: the product itself is presented as din, 3 ce-enabled edges to dout.
  always @(posedge clk) if (mul_ce) begin
    m0 <= din;
    m1 <= m0;
    m2 <= m1;
  end

  update_knn3_prod_acc dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mul_ce(mul_ce), .mul_dout(m2),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .sum_count(sum_count), .sum_ovf(sum_ovf)
  );

  update_knn3_prod_acc #(.ACC_WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready32), .mul_ce(mul_ce32), .mul_dout(m2),
    .sum_valid(sum_valid32), .sum_ready(sum_ready), .sum_data(sum_data32),
    .sum_count(sum_count32), .sum_ovf(sum_ovf32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [39:0] d40, input logic [7:0] c, input logic o40,
                      input logic [31:0] d32, input logic o32);
    q40.push_back('{data: d40, cnt: c, ovf: o40});
    q32.push_back('{data: {8'h0, d32}, cnt: c, ovf: o32});
  endtask

  // Monitor: a handshake at the coming edge pops one expected result per instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (reset_n && sum_valid && sum_ready) begin
        if (q40.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected40: got data %0h with empty queue", sum_data);
        end else begin
          e = q40.pop_front();
          check("sum_data40", 64'(sum_data), 64'(e.data));
          check("sum_count40", 64'(sum_count), 64'(e.cnt));
          check("sum_ovf40", 64'(sum_ovf), 64'(e.ovf));
        end
      end
      if (reset_n && sum_valid32 && sum_ready) begin
        if (q32.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected32: got data %0h with empty queue", sum_data32);
        end else begin
          e = q32.pop_front();
          check("sum_data32", 64'(sum_data32), 64'(e.data[31:0]));
          check("sum_count32", 64'(sum_count32), 64'(e.cnt));
          check("sum_ovf32", 64'(sum_ovf32), 64'(e.ovf));
        end
      end
    end
  end

  task automatic send(input logic [31:0] p, input logic last, output bit first_try);
    int tries;
    @(negedge clk);
    in_valid = 1'b1; in_last = last; din = p;
    #1;
    first_try = in_ready;
    tries = 0;
    while (!in_ready && tries < 200) begin
      @(negedge clk); #1;
      tries++;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_empty();
    int t = 0;
    while ((q40.size() != 0 || q32.size() != 0 || sum_valid) && t < 100) begin
      @(posedge clk); t++;
    end
    if (t >= 100) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: pending got %0d expected 0", q40.size());
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!sum_valid && t < 20) begin
      @(posedge clk); t++;
    end
    #1;
    check("wait_valid", 64'(sum_valid), 64'd1);
  endtask

  initial begin
    bit ft, ok;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum_valid", 64'(sum_valid), 64'd0);
    check("rst_sum_data", 64'(sum_data), 64'd0);
    check("rst_sum_count", 64'(sum_count), 64'd0);
    check("rst_sum_ovf", 64'(sum_ovf), 64'd0);
    check("rst_mul_ce", 64'(mul_ce), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) reset_n = 1'b1;

    // single term 3x5 and its latency
    send(32'd15, 1'b1, ft);
    push(40'd15, 8'd1, 1'b0, 32'd15, 1'b0);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("lat_early", 64'(sum_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_edge3", 64'(sum_valid), 64'd1);
    wait_empty();

    // four back-to-back terms
    ok = 1'b1;
    send(32'd1, 1'b0, ft); ok &= ft;
    send(32'd4, 1'b0, ft); ok &= ft;
    send(32'd9, 1'b0, ft); ok &= ft;
    send(32'd16, 1'b1, ft); ok &= ft;
    push(40'd30, 8'd4, 1'b0, 32'd30, 1'b0);
    idle(1);
    check("four_in_ready", 64'(ok), 64'd1);
    wait_empty();

    // consecutive single-term groups: publish coincides with drain
    send(32'd2, 1'b1, ft);  push(40'd2, 8'd1, 1'b0, 32'd2, 1'b0);
    send(32'd12, 1'b1, ft); push(40'd12, 8'd1, 1'b0, 32'd12, 1'b0);
    send(32'd30, 1'b1, ft); push(40'd30, 8'd1, 1'b0, 32'd30, 1'b0);
    idle(1);
    wait_empty();

    // gap inside a group
    send(32'd49, 1'b0, ft);
    idle(5);
    send(32'd6, 1'b1, ft);
    push(40'd55, 8'd2, 1'b0, 32'd55, 1'b0);
    idle(1);
    wait_empty();

    // back-pressure
    @(negedge clk) sum_ready = 1'b0;
    send(32'd42, 1'b1, ft);
    push(40'd42, 8'd1, 1'b0, 32'd42, 1'b0);
    idle(1);
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("bp_mul_ce", 64'(mul_ce), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_mul_ce32", 64'(mul_ce32), 64'd0);
      check("bp_sum_data", 64'(sum_data), 64'd42);
    end
    @(negedge clk) sum_ready = 1'b1;
    @(negedge clk) sum_ready = 1'b0;
    send(32'd100, 1'b0, ft);
    send(32'd1, 1'b1, ft);
    push(40'd101, 8'd2, 1'b0, 32'd101, 1'b0);
    idle(1);
    wait_valid();
    @(negedge clk) sum_ready = 1'b1;
    wait_empty();

    // overflow of the 32-bit instance
    send(32'hFFFF_0000, 1'b0, ft);
    send(32'h0002_0000, 1'b1, ft);
`ifdef UPDATE_KNN3_ACC_SAT_EN
    push(40'h01_0001_0000, 8'd2, 1'b0, 32'hFFFF_FFFF, 1'b1);
`else
    push(40'h01_0001_0000, 8'd2, 1'b0, 32'h0001_0000, 1'b1);
`endif
    send(32'hFFFF_0000, 1'b0, ft);
    send(32'h0002_0000, 1'b0, ft);
    send(32'h0000_0005, 1'b1, ft);
`ifdef UPDATE_KNN3_ACC_SAT_EN
    push(40'h01_0001_0005, 8'd3, 1'b0, 32'hFFFF_FFFF, 1'b1);
`else
    push(40'h01_0001_0005, 8'd3, 1'b0, 32'h0001_0005, 1'b1);
`endif
    idle(1);
    wait_empty();

    // term count saturates at 255
    for (int i = 0; i < 256; i++) send(32'd1, (i == 255), ft);
    push(40'd256, 8'd255, 1'b0, 32'd256, 1'b0);
    idle(1);
    wait_empty();

    // reset mid-group
    send(32'd7, 1'b0, ft);
    send(32'd8, 1'b0, ft);
    idle(1);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(sum_valid), 64'd0);
    check("mid_rst_data", 64'(sum_data), 64'd0);
    check("mid_rst_count", 64'(sum_count), 64'd0);
    check("mid_rst_ovf", 64'(sum_ovf), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    send(32'd4, 1'b1, ft);
    push(40'd4, 8'd1, 1'b0, 32'd4, 1'b0);
    idle(6);
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
